// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, the transmitter and the RX FIFO.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// RX FIFO storage: registered write port, asynchronous read port, no reset on the array.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word fall-through RX FIFO with sticky overflow flag.
// Define UART_RX_FIFO_OVF_CNT_EN to add the saturating ovf_count output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   button,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
`ifdef UART_RX_FIFO_OVF_CNT_EN
  output logic [7:0]             ovf_count,
`endif
  input  logic                   clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign rd_valid = !empty;
  assign count    = count_q;
  assign overflow = overflow_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge button) begin
    if (!button) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge button) begin
    if (!button) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CW'(1);
    end
  end

  // A drop in the same cycle as the clear keeps the flag set.
  always_ff @(posedge clk or negedge button) begin
    if (!button) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge button) begin
    if (!button) begin
      ovf_cnt_q <= 8'd0;
    end else if (clr_overflow) begin
      ovf_cnt_q <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_cnt_q <= sat_inc8(ovf_cnt_q);
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks every pop.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   button = 1'b0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic                   wr_en = 1'b0;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;
  logic                   rd_ready = 1'b0;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clr_overflow = 1'b0;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0]             ovf_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .button       (button),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
`ifdef UART_RX_FIFO_OVF_CNT_EN
    .ovf_count    (ovf_count),
`endif
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (button && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {24'd0, rd_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      exp_q.push_back(base + 8'(i));
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
    check("drained_queue", exp_q.size(), 0);
    check("drained_empty", {31'd0, empty}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_valid", {31'd0, rd_valid}, 0);
    check("rst_count", count, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    @(posedge clk); #1;
    button = 1'b1;
    tick();

    // Three pushes, first one visible the cycle after its edge
    wr_en = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
    tick();
    check("first_valid", {31'd0, rd_valid}, 1);
    check("first_data", {24'd0, rd_data}, 32'h41);
    wr_data = 8'h42; exp_q.push_back(8'h42);
    tick();
    wr_data = 8'h43; exp_q.push_back(8'h43);
    tick();
    wr_en = 1'b0;
    check("three_count", count, 3);
    check("three_head", {24'd0, rd_data}, 32'h41);
    drain(3);
    // rd_ready while empty must not move anything
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("empty_rdy_count", count, 0);
    check("empty_rdy_empty", {31'd0, empty}, 1);

    // Fill, then a dropped write
    fill(8'h00);
    check("fill_full", {31'd0, full}, 1);
    check("fill_count", count, 16);
    check("fill_ovf", {31'd0, overflow}, 0);
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("drop_ovf", {31'd0, overflow}, 1);
    check("drop_count", count, 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 0);
    wr_en = 1'b1; wr_data = 8'hAA; clr_overflow = 1'b1;
    tick();
    wr_en = 1'b0; clr_overflow = 1'b0;
    check("set_wins_ovf", {31'd0, overflow}, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    drain(16);

    // Full with simultaneous write and pop
    fill(8'h60);
    wr_en = 1'b1; wr_data = 8'h55; rd_ready = 1'b1; exp_q.push_back(8'h55);
    tick();
    wr_en = 1'b0; rd_ready = 1'b0;
    check("fullpop_count", count, 16);
    check("fullpop_ovf", {31'd0, overflow}, 0);
    check("fullpop_full", {31'd0, full}, 1);
    drain(16);

    // Streaming 40 bytes through, pointers wrap twice
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i); exp_q.push_back(8'h10 + 8'(i));
      tick();
      check("stream_count_le1", {31'd0, (count <= 1)}, 1);
    end
    wr_en = 1'b0;
    drain(1);

    // Async reset with 5 bytes stored
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h01 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("pre_rst_count", count, 5);
    #2;
    button = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_empty", {31'd0, empty}, 1);
    check("async_rst_valid", {31'd0, rd_valid}, 0);
    tick();
    button = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h7E; exp_q.push_back(8'h7E);
    tick();
    wr_en = 1'b0;
    check("post_rst_data", {24'd0, rd_data}, 32'h7E);
    check("post_rst_count", count, 1);
    drain(1);

`ifdef UART_RX_FIFO_OVF_CNT_EN
    fill(8'hC0);
    wr_en = 1'b1; wr_data = 8'hEE;
    repeat (300) tick();
    wr_en = 1'b0;
    check("ovfcnt_sat", {24'd0, ovf_count}, 255);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovfcnt_clr", {24'd0, ovf_count}, 0);
    wr_en = 1'b1; clr_overflow = 1'b1;
    tick();
    wr_en = 1'b0; clr_overflow = 1'b0;
    check("ovfcnt_clr_drop", {24'd0, ovf_count}, 1);
    drain(16);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, which sets the FIFO entry count (power of 2, range 2..256).
REQ-002 SHALL have parameter DATA_W, default 8, which sets the byte width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port button, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port wr_data, input, DATA_W bits: the byte from the UART receiver.
REQ-006 SHALL have port wr_en, input, 1 bit: a one-cycle strobe from the receiver on stop-bit completion.
REQ-007 SHALL have port rd_data, output, DATA_W bits: the head-of-FIFO byte, first-word fall-through.
REQ-008 SHALL have port rd_valid, output, 1 bit: high when the FIFO is not empty.
REQ-009 SHALL have port rd_ready, input, 1 bit: the downstream consumer (UART transmitter or LED decoder) accepts the head.
REQ-010 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-011 SHALL have port empty, output, 1 bit: count == 0.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-014 SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.

Function
REQ-015 Push = wr_en && (!full || pop); pop = rd_valid && rd_ready.
REQ-016 Push writes wr_data at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-017 Pop increments rd_ptr modulo DEPTH; rd_data reflects the new head the same cycle rd_ptr updates.
REQ-018 count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 Write-to-read latency: byte pushed at edge N is visible (rd_valid=1) after edge N, i.e. cycle N+1; no same-cycle bypass when empty.
REQ-020 Full and pop in the same cycle: write accepted, count stays DEPTH, overflow not set.
REQ-021 wr_en while full without pop: byte dropped, FIFO contents/pointers unchanged, overflow set at next edge.
REQ-022 Empty and rd_ready=1: no pop, pointers unchanged; rd_data is don't-care.
REQ-023 overflow set and clr_overflow in the same cycle: set wins.
REQ-024 Byte order SHALL be strictly preserved across pointer wrap-around.

Reset
REQ-025 button low asynchronously clears wr_ptr, rd_ptr and count to 0, and overflow to 0.
REQ-026 During reset: empty=1, full=0, rd_valid=0; storage array contents are not reset.
REQ-027 Reset mid-operation discards all stored bytes; the first push after release lands at entry 0.

Configuration
REQ-028 Macro UART_RX_FIFO_OVF_CNT_EN defined: adds output ovf_count[7:0], counts dropped writes, saturates at 255, reset to 0, cleared by clr_overflow (a drop in the same cycle leaves it at 1).
REQ-029 Macro undefined: no ovf_count port and no counter logic; all other behaviour identical.

Structure
REQ-030 Package uart_pkg SHALL hold UART_DATA_W=8 and UART_RX_FIFO_DEPTH=16 constants, shared with the receiver and transmitter.
REQ-031 Storage SHALL be sub-module uart_fifo_mem: registered write port, asynchronous read port, no reset.
REQ-032 Pointer, count, flag and handshake logic SHALL live in uart_rx_fifo.

Verification
REQ-033 Reset, then push 0x41, 0x42, 0x43 on consecutive cycles with rd_ready=0 -> count=3, rd_data=0x41, rd_valid=1 from the cycle after the first push.
REQ-034 Push 16 bytes 0x00..0x0F, then a 17th byte 0xAA with rd_ready=0 -> full=1, overflow=1, pops return 0x00..0x0F in order and 0xAA never appears.
REQ-035 Full FIFO, wr_en=1 with 0x55 and rd_ready=1 in the same cycle -> count stays 16, overflow=0, 0x55 emerges 16th.
REQ-036 Continuous push/pop of 40 bytes 0x10..0x37 (pointer wrap twice) -> output sequence identical, count never exceeds 1.
REQ-037 Assert button low with count=5 -> count=0, empty=1 immediately; after release, push 0x7E -> rd_data=0x7E.
REQ-038 With UART_RX_FIFO_OVF_CNT_EN, force 300 drops -> ovf_count=255; clr_overflow -> 0.
